// File: rtl/lsu_pkg.sv
// Shared types and address-map constants for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RESP
   } state_e;

   typedef enum logic [2:0] {
      IO_NONE,
      IO_LEDR,
      IO_LEDG,
      IO_HEX,
      IO_LCD,
      IO_SW
   } io_e;

   localparam logic [31:0] DMEM_LIMIT = 32'h0000_2000;
   localparam logic [31:0] ADDR_LEDR  = 32'h0000_7000;
   localparam logic [31:0] ADDR_LEDG  = 32'h0000_7010;
   localparam logic [31:0] ADDR_HEX   = 32'h0000_7020;
   localparam logic [31:0] ADDR_LCD   = 32'h0000_7030;
   localparam logic [31:0] ADDR_SW    = 32'h0000_7800;

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads and read-modify-write merge for stores.
// Sub-word lanes exist only when LSU_SUBWORD_EN is defined; otherwise data passes through as words.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] word_i,
   input  logic [N-1:0] wdata_i,
   input  logic [1:0]   lane_i,
   input  logic [1:0]   size_i,
   input  logic         unsigned_i,
   output logic [N-1:0] ld_data_o,
   output logic [N-1:0] st_word_o
);

`ifdef LSU_SUBWORD_EN
   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      byte_sh   = {lane_i, 3'b000};
      half_sh   = {lane_i[1], 4'b0000};
      lane_b    = word_i[byte_sh +: 8];
      lane_h    = word_i[half_sh +: 16];
      ld_data_o = word_i;
      st_word_o = wdata_i;
      case (size_e'(size_i))
         SZ_BYTE: begin
            ld_data_o                 = {{(N-8){lane_b[7] & ~unsigned_i}}, lane_b};
            st_word_o                 = word_i;
            st_word_o[byte_sh +: 8]   = wdata_i[7:0];
         end
         SZ_HALF: begin
            ld_data_o                 = {{(N-16){lane_h[15] & ~unsigned_i}}, lane_h};
            st_word_o                 = word_i;
            st_word_o[half_sh +: 16]  = wdata_i[15:0];
         end
         default: ;
      endcase
   end
`else
   logic unused_lane;

   assign unused_lane = ^{lane_i, size_i, unsigned_i};
   assign ld_data_o   = word_i;
   assign st_word_o   = wdata_i;
`endif

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: DMEM at 0x0000-0x1FFF plus word-only IO registers at 0x7000-0x7800.
// LSU_SUBWORD_EN enables byte/half accesses (sub-word stores go through RD->WR merge).
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int N      = 32,
   parameter int ADDR_W = 11
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [31:0]       req_addr_i,
   input  logic [N-1:0]      req_wdata_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   output logic              rsp_valid_o,
   output logic [N-1:0]      rsp_rdata_o,
   output logic              rsp_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [N-1:0]      mem_st_data_o,
   output logic              mem_st_en_o,
   input  logic [N-1:0]      mem_ld_data_i,
   input  logic [N-1:0]      io_sw_i,
   output logic [N-1:0]      io_ledr_o,
   output logic [N-1:0]      io_ledg_o,
   output logic [N-1:0]      io_hex_o,
   output logic [N-1:0]      io_lcd_o
);

   state_e            state_q;
   logic              ready_q, rsp_valid_q, err_q, from_mem_q, st_en_q, we_q, uns_q;
   logic [1:0]        size_q, lane_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [N-1:0]      wdata_q, rdata_q, ledr_q, ledg_q, hex_q, lcd_q;
   io_e               io_sel_d;
   logic              err_d, size_ok_d;
   logic [N-1:0]      io_rdata_d, ld_ext, st_word;

   always_comb begin
      case (req_addr_i)
         ADDR_LEDR: io_sel_d = IO_LEDR;
         ADDR_LEDG: io_sel_d = IO_LEDG;
         ADDR_HEX:  io_sel_d = IO_HEX;
         ADDR_LCD:  io_sel_d = IO_LCD;
         ADDR_SW:   io_sel_d = IO_SW;
         default:   io_sel_d = IO_NONE;
      endcase
      case (io_sel_d)
         IO_LEDR: io_rdata_d = ledr_q;
         IO_LEDG: io_rdata_d = ledg_q;
         IO_HEX:  io_rdata_d = hex_q;
         IO_LCD:  io_rdata_d = lcd_q;
         IO_SW:   io_rdata_d = io_sw_i;
         default: io_rdata_d = '0;
      endcase
`ifdef LSU_SUBWORD_EN
      size_ok_d = size_e'(req_size_i) != SZ_BAD;
`else
      size_ok_d = size_e'(req_size_i) == SZ_WORD;
`endif
      err_d = !size_ok_d
            || (size_e'(req_size_i) == SZ_HALF && req_addr_i[0])
            || (size_e'(req_size_i) == SZ_WORD && req_addr_i[1:0] != 2'b00)
            || (io_sel_d == IO_NONE && req_addr_i >= DMEM_LIMIT)
            || (io_sel_d != IO_NONE && size_e'(req_size_i) != SZ_WORD)
            || (io_sel_d == IO_SW && req_we_i);
   end

   // NOTE: async-reset sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
         from_mem_q  <= 1'b0;
         st_en_q     <= 1'b0;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         size_q      <= 2'b00;
         lane_q      <= 2'b00;
         mem_addr_q  <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         ledr_q      <= '0;
         ledg_q      <= '0;
         hex_q       <= '0;
         lcd_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (req_valid_i) begin
               ready_q    <= 1'b0;
               we_q       <= req_we_i;
               uns_q      <= req_unsigned_i;
               size_q     <= req_size_i;
               lane_q     <= req_addr_i[1:0];
               wdata_q    <= req_wdata_i;
               mem_addr_q <= req_addr_i[ADDR_W+1:2];
               err_q      <= err_d;
               rdata_q    <= '0;
               if (err_d || io_sel_d != IO_NONE) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  if (!err_d && !req_we_i) rdata_q <= io_rdata_d;
                  if (!err_d && req_we_i) begin
                     case (io_sel_d)
                        IO_LEDR: ledr_q <= req_wdata_i;
                        IO_LEDG: ledg_q <= req_wdata_i;
                        IO_HEX:  hex_q  <= req_wdata_i;
                        IO_LCD:  lcd_q  <= req_wdata_i;
                        default: ;
                     endcase
                  end
               end else if (!req_we_i || size_e'(req_size_i) != SZ_WORD) begin
                  state_q <= S_RD;
               end else begin
                  state_q <= S_WR;
                  st_en_q <= 1'b1;
               end
            end
            S_RD: begin
               // Memory data for this address is valid in the following state.
               if (we_q) begin
                  state_q <= S_WR;
                  st_en_q <= 1'b1;
               end else begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  from_mem_q  <= 1'b1;
               end
            end
            S_WR: begin
               st_en_q     <= 1'b0;
               state_q     <= S_RESP;
               rsp_valid_q <= 1'b1;
            end
            S_RESP: begin
               state_q     <= S_IDLE;
               ready_q     <= 1'b1;
               rsp_valid_q <= 1'b0;
               from_mem_q  <= 1'b0;
               err_q       <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   lsu_align #(.N(N)) u_align (
      .word_i     (mem_ld_data_i),
      .wdata_i    (wdata_q),
      .lane_i     (lane_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .ld_data_o  (ld_ext),
      .st_word_o  (st_word)
   );

   assign req_ready_o   = ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_err_o     = rsp_valid_q & err_q;
   assign rsp_rdata_o   = !rsp_valid_q ? '0 : (from_mem_q ? ld_ext : rdata_q);
   assign mem_addr_o    = mem_addr_q;
   assign mem_st_en_o   = st_en_q;
   assign mem_st_data_o = st_en_q ? st_word : '0;
   assign io_ledr_o     = ledr_q;
   assign io_ledg_o     = ledg_q;
   assign io_hex_o      = hex_q;
   assign io_lcd_o      = lcd_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed vector bench for lsu_ctrl with a synchronous-read DMEM model.
// Expectations follow the LSU_SUBWORD_EN setting of the build.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0, io_sw = '0;
   logic [1:0]  req_size = 2'b10;
   logic        req_ready, rsp_valid, rsp_err, mem_st_en;
   logic [31:0] rsp_rdata, mem_st_data, mem_ld_data;
   logic [10:0] mem_addr;
   logic [31:0] ledr, ledg, hex, lcd;

   logic [31:0] dmem [2048];
   int          pass_cnt = 0;
   int          total_cnt = 0;

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] sw;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          exp_st;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   lsu_ctrl #(.N(32), .ADDR_W(11)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
      .req_unsigned_i(req_unsigned),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .mem_addr_o(mem_addr), .mem_st_data_o(mem_st_data), .mem_st_en_o(mem_st_en),
      .mem_ld_data_i(mem_ld_data), .io_sw_i(io_sw),
      .io_ledr_o(ledr), .io_ledg_o(ledg), .io_hex_o(hex), .io_lcd_o(lcd)
   );

   always @(posedge clk) begin
      if (mem_st_en) dmem[mem_addr] <= mem_st_data;
      mem_ld_data <= dmem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic add(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                      input logic [31:0] sw, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_lat, input int exp_st);
      vec_t v;
      v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
      v.uns = uns; v.sw = sw; v.exp_rd = exp_rd; v.exp_err = exp_err;
      v.exp_lat = exp_lat; v.exp_st = exp_st;
      vecs.push_back(v);
   endtask

   task automatic issue(input vec_t v);
      @(negedge clk);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
      req_size = v.size; req_unsigned = v.uns; io_sw = v.sw;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      io_sw = ~v.sw;
   endtask

   task automatic run_check(input vec_t v);
      int          lat = 0, stc = 0;
      logic [31:0] rd = '0;
      logic        er = 1'b0;
      logic [10:0] sta = '0;
      issue(v);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_st_en) begin stc++; sta = mem_addr; end
         if (rsp_valid) begin lat = c; rd = rsp_rdata; er = rsp_err; break; end
      end
      check({v.name, " latency"}, lat, v.exp_lat);
      check({v.name, " rdata"}, rd, v.exp_rd);
      check({v.name, " err"}, {31'd0, er}, {31'd0, v.exp_err});
      check({v.name, " st_en pulses"}, stc, v.exp_st);
      if (stc > 0) check({v.name, " st addr"}, {21'd0, sta}, 32'd4);
      @(negedge clk);
      check({v.name, " after rsp"}, {28'd0, rsp_valid, rsp_err, req_ready, |rsp_rdata}, 32'h2);
   endtask

   localparam logic [31:0] FINAL_WORD =
`ifdef LSU_SUBWORD_EN
      32'hBEEF3344;
`else
      32'h11223344;
`endif

   initial begin
      int hits;
      vec_t v;

      add("sw_dmem",  1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, 32'h0,        0, 2, 1);
      add("lw_dmem",  0, 32'h10, 32'h0,        2'b10, 0, 0, 32'hDEADBEEF, 0, 2, 0);
      add("sw_base",  1, 32'h10, 32'h11223344, 2'b10, 0, 0, 32'h0,        0, 2, 1);
`ifdef LSU_SUBWORD_EN
      add("sb_5a",    1, 32'h13, 32'h5A,       2'b00, 0, 0, 32'h0,        0, 3, 1);
      add("lw_merge", 0, 32'h10, 32'h0,        2'b10, 0, 0, 32'h5A223344, 0, 2, 0);
      add("lb_5a",    0, 32'h13, 32'h0,        2'b00, 0, 0, 32'h0000005A, 0, 2, 0);
      add("lbu_5a",   0, 32'h13, 32'h0,        2'b00, 1, 0, 32'h0000005A, 0, 2, 0);
      add("sb_a5",    1, 32'h13, 32'hA5,       2'b00, 0, 0, 32'h0,        0, 3, 1);
      add("lb_a5",    0, 32'h13, 32'h0,        2'b00, 0, 0, 32'hFFFFFFA5, 0, 2, 0);
      add("lbu_a5",   0, 32'h13, 32'h0,        2'b00, 1, 0, 32'h000000A5, 0, 2, 0);
      add("lb_lane0", 0, 32'h10, 32'h0,        2'b00, 0, 0, 32'h00000044, 0, 2, 0);
      add("sh_beef",  1, 32'h12, 32'h1234BEEF, 2'b01, 0, 0, 32'h0,        0, 3, 1);
      add("lh_beef",  0, 32'h12, 32'h0,        2'b01, 0, 0, 32'hFFFFBEEF, 0, 2, 0);
      add("lhu_beef", 0, 32'h12, 32'h0,        2'b01, 1, 0, 32'h0000BEEF, 0, 2, 0);
`else
      add("sb_off",   1, 32'h13, 32'h5A,       2'b00, 0, 0, 32'h0,        1, 1, 0);
      add("lb_off",   0, 32'h13, 32'h0,        2'b00, 0, 0, 32'h0,        1, 1, 0);
`endif
      add("lw_word",  0, 32'h10, 32'h0,        2'b10, 0, 0, FINAL_WORD,   0, 2, 0);
      add("sw_ledr",  1, 32'h7000, 32'h0000000F, 2'b10, 0, 0, 32'h0,      0, 1, 0);
      add("lw_ledr",  0, 32'h7000, 32'h0,      2'b10, 0, 0, 32'h0000000F, 0, 1, 0);
      add("lw_sw",    0, 32'h7800, 32'h0,      2'b10, 0, 32'h123, 32'h123, 0, 1, 0);
      add("sw_lcd",   1, 32'h7030, 32'hAB,     2'b10, 0, 0, 32'h0,        0, 1, 0);
      add("lh_misal", 0, 32'h1,  32'h0,        2'b01, 0, 0, 32'h0,        1, 1, 0);
      add("lw_misal", 0, 32'h2,  32'h0,        2'b10, 0, 0, 32'h0,        1, 1, 0);
      add("sw_to_sw", 1, 32'h7800, 32'h77,     2'b10, 0, 0, 32'h0,        1, 1, 0);
      add("lw_unmap", 0, 32'h2000, 32'h0,      2'b10, 0, 0, 32'h0,        1, 1, 0);
      add("st_size3", 1, 32'h10, 32'hCAFEF00D, 2'b11, 0, 0, 32'h0,        1, 1, 0);
      add("lb_io",    0, 32'h7000, 32'h0,      2'b00, 0, 0, 32'h0,        1, 1, 0);
      add("lw_keep",  0, 32'h10, 32'h0,        2'b10, 0, 0, FINAL_WORD,   0, 2, 0);

      // Reset state, sampled while reset is held.
      #12;
      check("reset outputs", {28'd0, req_ready, rsp_valid, rsp_err, mem_st_en}, 32'h8);
      check("reset rdata/addr", rsp_rdata | {21'd0, mem_addr} | mem_st_data, 32'h0);
      check("reset io regs", ledr | ledg | hex | lcd, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) run_check(vecs[i]);

      check("io ledr", ledr, 32'h0000000F);
      check("io lcd", lcd, 32'h000000AB);
      check("io ledg/hex", ledg | hex, 32'h0);

      // Abort during RD: no write, no response, ready after release.
      v = vecs[0];
      v.name = "abort_rd"; v.addr = 32'h10; v.wdata = 32'h99;
`ifdef LSU_SUBWORD_EN
      v.we = 1'b1; v.size = 2'b00;
`else
      v.we = 1'b0; v.size = 2'b10;
`endif
      issue(v);
      @(negedge clk);
      check("abort_rd in RD", {30'd0, req_ready, rsp_valid}, 32'h0);
      rst = 1'b1;
      #1;
      check("abort_rd async", {30'd0, req_ready, mem_st_en}, 32'h2);
      @(negedge clk);
      rst = 1'b0;
      hits = 0;
      repeat (4) begin
         @(negedge clk);
         if (mem_st_en || rsp_valid) hits++;
      end
      check("abort_rd no activity", hits, 0);
      check("abort_rd ready", {31'd0, req_ready}, 32'h1);
      check("abort io cleared", ledr | lcd, 32'h0);

      // Abort during WR: strobe must drop with reset itself.
      v.name = "abort_wr"; v.we = 1'b1; v.size = 2'b10; v.addr = 32'h10; v.wdata = 32'h55;
      issue(v);
      @(negedge clk);
      check("abort_wr st_en high", {31'd0, mem_st_en}, 32'h1);
      rst = 1'b1;
      #1;
      check("abort_wr st_en async", {31'd0, mem_st_en}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      run_check(vecs[vecs.size()-1]);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
